// File: rtl/booth_mult_iter_pkg.sv
// Shared definitions for the iterative Booth multiplier.
// Latency: n/a (types only).
// Backpressure: n/a.
package booth_mult_iter_pkg;

  // Control FSM encoding: one pass is IDLE -> RUN (WIDTH steps) -> DONE -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Booth select, formed as {L[0], q_m1}.
  typedef enum logic [1:0] {
    BOOTH_NOP0 = 2'b00,
    BOOTH_ADD  = 2'b01,
    BOOTH_SUB  = 2'b10,
    BOOTH_NOP1 = 2'b11
  } booth_sel_e;

endpackage

// File: rtl/booth_mult_iter_if.sv
// Start/operand/result bundle between the multdiv control and the Booth multiplier.
// Latency: n/a (wires only).
// Backpressure: none; ctrl_MULT is a start pulse and data_resultRDY a one-cycle done pulse.
//   master: drives ctrl_MULT, data_operandA, data_operandB; reads the result group.
//   slave : the multiplier; drives data_result, data_exception, data_resultRDY.
interface booth_mult_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/booth_mult_iter_cla_adder_w.sv
// WIDTH-bit two-level carry-lookahead adder: 8-bit CLA groups plus lookahead on group G/P.
// Latency: combinational.
// Backpressure: none.
//   a, b, cin -> sum (WIDTH bits), cout (carry out of bit WIDTH-1).
module cla_adder_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG = WIDTH / 8;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [NG:0]      grp_c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate. Each accumulation walks from the top bit down so that
  // gacc ends up as OR_j g[j] & p[j+1..7], the group carry-out with zero carry-in.
  always_comb begin
    logic gacc;
    logic pacc;
    gacc  = 1'b0;
    pacc  = 1'b1;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = 7; j >= 0; j--) begin
        gacc = gacc | (pacc & g[8*k+j]);
        pacc = pacc & p[8*k+j];
      end
      grp_g[k] = gacc;
      grp_p[k] = pacc;
    end
  end

  // Second level: carry into group k expanded directly from group G/P and cin.
  always_comb begin
    logic gacc;
    logic pacc;
    gacc  = 1'b0;
    pacc  = 1'b1;
    grp_c = '0;
    for (int k = 0; k <= NG; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        gacc = gacc | (pacc & grp_g[j]);
        pacc = pacc & grp_p[j];
      end
      grp_c[k] = gacc | (pacc & cin);
    end
  end

  // First level: bit carries inside each group from that group's lookahead carry-in.
  always_comb begin
    logic gacc;
    logic pacc;
    gacc = 1'b0;
    pacc = 1'b1;
    c    = '0;
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 8; i++) begin
        gacc = 1'b0;
        pacc = 1'b1;
        for (int j = i - 1; j >= 0; j--) begin
          gacc = gacc | (pacc & g[8*k+j]);
          pacc = pacc & p[8*k+j];
        end
        c[8*k+i] = gacc | (pacc & grp_c[k]);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[NG];

endmodule

// File: rtl/booth_mult_iter.sv
// Iterative radix-2 Booth signed multiplier, WIDTH x WIDTH -> low WIDTH bits + overflow flag.
// Latency: RDY pulses in the cycle after the (WIDTH+1)th edge following the start edge.
// Backpressure: none; a new ctrl_MULT aborts any operation in flight, reset aborts silently.
//   clock/reset : single clock, synchronous active-high reset.
//   bus (slave) : ctrl_MULT + operands in; data_result/data_exception/data_resultRDY out.
module booth_mult_iter
  import booth_mult_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  booth_mult_iter_if.slave  bus
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d, count_inc;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH:0]     u_q, u_d;
  logic [WIDTH-1:0]   l_q, l_d;
  logic               qm1_q, qm1_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;

  logic               start;
  logic               done_fire;
  booth_sel_e         booth_sel;
  logic [WIDTH-1:0]   add_b;
  logic               add_cin;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH:0]     u_step;

  assign start     = bus.ctrl_MULT;
  assign booth_sel = booth_sel_e'({l_q[0], qm1_q});

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // A start in any state restarts the operation.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN:  if (count_q == LAST_CNT) state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Results are captured only when DONE completes without a competing restart, and
  // otherwise hold (they are deliberately not cleared on start).
  always_comb begin
    done_fire = (state_q == ST_DONE) && !start;
    rdy_d     = done_fire;
    result_d  = result_q;
    exc_d     = exc_q;
    if (done_fire) begin
      result_d = l_q;
      exc_d    = (u_q[WIDTH-1:0] != {WIDTH{l_q[WIDTH-1]}});
    end
  end

  // ---------------- Booth step datapath ----------------
  // Subtract is U + ~M + 1 through the same adder.
  always_comb begin
    add_b   = m_q;
    add_cin = 1'b0;
    if (booth_sel == BOOTH_SUB) begin
      add_b   = ~m_q;
      add_cin = 1'b1;
    end
  end

  cla_adder_w #(.WIDTH(WIDTH)) u_adder (
    .a    (u_q[WIDTH-1:0]),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Guard bit is the true sign of the (WIDTH+1)-bit sum: the sign-extended operand
  // bits XOR the carry out of the WIDTH-bit adder. Needed for M = MIN, where U can
  // reach +2**(WIDTH-1) before the shift.
  always_comb begin
    u_step = u_q;
    if ((booth_sel == BOOTH_ADD) || (booth_sel == BOOTH_SUB)) begin
      u_step = {u_q[WIDTH] ^ add_b[WIDTH-1] ^ add_cout, add_sum};
    end
  end

  // Ripple incrementer for the step counter, kept out of the arithmetic path.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = '0;
    for (int i = 0; i < CNT_W; i++) begin
      count_inc[i] = count_q[i] ^ carry;
      carry        = carry & count_q[i];
    end
  end

  always_comb begin
    m_d     = m_q;
    u_d     = u_q;
    l_d     = l_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    if (start) begin
      m_d     = bus.data_operandA;
      l_d     = bus.data_operandB;
      u_d     = '0;
      qm1_d   = 1'b0;
      count_d = '0;
    end else if (state_q == ST_RUN) begin
      // Arithmetic shift right of {U, L, q_m1}, U's guard bit replicated.
      u_d     = {u_step[WIDTH], u_step[WIDTH:1]};
      l_d     = {u_step[0], l_q[WIDTH-1:1]};
      qm1_d   = l_q[0];
      count_d = count_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_q      <= '0;
      u_q      <= '0;
      l_q      <= '0;
      qm1_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      m_q      <= m_d;
      u_q      <= u_d;
      l_q      <= l_d;
      qm1_q    <= qm1_d;
      count_q  <= count_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_mult_iter.sv
// Bench for booth_mult_iter: directed vector table, multi-cycle corner sequences, random pairs.
// Latency: expects RDY exactly WIDTH+1 edges after the start edge.
// Backpressure: n/a.
module tb_booth_mult_iter;
  localparam int W = 32;
  localparam int LAT = W + 1;

  logic clock;
  logic reset;

  booth_mult_iter_if #(.WIDTH(W)) bus ();

  booth_mult_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives a one-edge start pulse; returns #1 after the start edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
  endtask

  // Number of edges until RDY is seen, or -1 if the budget expires.
  task automatic wait_rdy(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    longint pa, pb, prod;
    logic [W-1:0] ra, rb, exp_res;
    logic exp_exc;

    vecs[0]  = '{32'd3,        32'd4,        32'd12,       1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{32'd0,        32'h80000000, 32'd0,        1'b0};
    vecs[3]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[5]  = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h80000000, 32'd0,        1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
    vecs[8]  = '{32'h00010000, 32'h00010000, 32'd0,        1'b1};
    vecs[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1,        1'b1};
    vecs[10] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b1};
    vecs[11] = '{32'h12345678, 32'd0,        32'd0,        1'b0};

    bus.ctrl_MULT     = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    check("reset_result", 64'(bus.data_result), 64'd0);
    check("reset_exc",    64'(bus.data_exception), 64'd0);
    check("reset_rdy",    64'(bus.data_resultRDY), 64'd0);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_rdy(3 * LAT, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_result", i), 64'(bus.data_result), 64'(vecs[i].res));
      check($sformatf("vec%0d_exc", i), 64'(bus.data_exception), 64'(vecs[i].exc));
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_rdy_pulse", i), 64'(bus.data_resultRDY), 64'd0);
      check($sformatf("vec%0d_hold", i), 64'(bus.data_result), 64'(vecs[i].res));
    end

    // ctrl_MULT held high for five edges: only the last operands (6*7) complete.
    bus.ctrl_MULT = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_operandA = W'(i + 2);
      bus.data_operandB = 32'd7;
      @(posedge clock);
      #1;
    end
    bus.ctrl_MULT = 1'b0;
    wait_rdy(3 * LAT, lat);
    check("held_latency", 64'(lat), 64'(LAT));
    check("held_result", 64'(bus.data_result), 64'd42);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("held_extra_rdy", 64'(pulses), 64'd0);

    // Restart mid-run: 5*5 aborted at cycle 10 by 9*-3.
    start_op(32'd5, 32'd5);
    pulses = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("abort_early_rdy", 64'(pulses), 64'd0);
    start_op(32'd9, 32'hFFFFFFFD);
    lat = -1;
    pulses = 0;
    for (int n = 1; n <= 3 * LAT; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          check("abort_result", 64'(bus.data_result), 64'hFFFFFFE5);
          check("abort_exc", 64'(bus.data_exception), 64'd0);
        end
      end
    end
    check("abort_latency", 64'(lat), 64'(LAT));
    check("abort_rdy_count", 64'(pulses), 64'd1);

    // Random signed pairs against a 64-bit product.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 1) ra = W'($signed(12'($urandom)));
      if (i % 4 == 2) rb = W'($signed(10'($urandom)));
      pa = longint'($signed(ra));
      pb = longint'($signed(rb));
      prod = pa * pb;
      exp_res = prod[W-1:0];
      exp_exc = (prod != longint'($signed(exp_res)));
      start_op(ra, rb);
      wait_rdy(3 * LAT, lat);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("rnd%0d_result a=%0h b=%0h", i, ra, rb), 64'(bus.data_result), 64'(exp_res));
      check($sformatf("rnd%0d_exc a=%0h b=%0h", i, ra, rb), 64'(bus.data_exception), 64'(exp_exc));
    end

    // Reset at cycle 15 of 100*100: no RDY afterwards, outputs cleared.
    start_op(32'd100, 32'd100);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_mid_result", 64'(bus.data_result), 64'd0);
    check("rst_mid_exc", 64'(bus.data_exception), 64'd0);
    pulses = 0;
    for (int n = 0; n < 2 * LAT; n++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY) pulses++;
    end
    check("rst_mid_no_rdy", 64'(pulses), 64'd0);
    check("rst_mid_result_after", 64'(bus.data_result), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
